// File: rtl/mini_src_pkg.sv
// Shared opcode values, FSM state encoding and opcode classes for the Mini-SRC control unit.
package mini_src_pkg;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShl  = 5'b01000;
  localparam logic [4:0] OpRor  = 5'b01001;
  localparam logic [4:0] OpRol  = 5'b01010;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu2, ClsAlu1, ClsMulDiv, ClsNop, ClsHalt, ClsIllegal
  } op_class_e;

endpackage

// File: rtl/mini_src_op_decode.sv
// Combinational opcode classifier: maps IR[31:27] to the execute-sequence class.
module mini_src_op_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode_i,
  output op_class_e  op_class_o
);

  always_comb begin
    op_class_o = ClsIllegal;
    case (opcode_i)
      OpAdd, OpSub, OpAnd, OpOr,
      OpShr, OpShl, OpRor, OpRol: op_class_o = ClsAlu2;
      OpNeg, OpNot:               op_class_o = ClsAlu1;
      OpMul, OpDiv:               op_class_o = ClsMulDiv;
      OpNop:                      op_class_o = ClsNop;
      OpHalt:                     op_class_o = ClsHalt;
      default:                    op_class_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Mini-SRC sequencer: fetch T0-T2, class-dependent execute T3-T6, Moore strobes.
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           Zhighin,
  output logic           Zlowin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal
);

  state_e    state_q, state_d;
  op_class_e op_class;
  logic      t1_entry_q;
  logic      at_boundary;
  logic      unused_ir;

  // Register fields are consumed by the datapath's select-and-encode logic, not here.
  assign unused_ir = ^ir[26:0];

  mini_src_op_decode u_op_decode (
    .opcode_i   (ir[31:27]),
    .op_class_o (op_class)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= StReset;
      t1_entry_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t1_entry_q <= (state_q == StT0);
    end
  end

  always_comb begin
    state_d     = state_q;
    at_boundary = 1'b0;
    case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    if (mem_ready) state_d = StT2;
      StT2:    state_d = StT3;
      StT3: begin
        case (op_class)
          ClsAlu2, ClsAlu1, ClsMulDiv: state_d = StT4;
          ClsHalt:                     state_d = StHalt;
          default:                     at_boundary = 1'b1;
        endcase
      end
      StT4: begin
        if (op_class == ClsAlu1) at_boundary = 1'b1;
        else                     state_d = StT5;
      end
      StT5: begin
        if (op_class == ClsAlu2) at_boundary = 1'b1;
        else                     state_d = StT6;
      end
      StT6:    at_boundary = 1'b1;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
    // Halt requests only take effect once the current instruction has fully retired.
    if (at_boundary) state_d = stop ? StHalt : StT0;
  end

  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Zhighin  = 1'b0;
    Zlowin   = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = '0;
    illegal  = 1'b0;
    run      = (state_q != StReset) && (state_q != StHalt);
    case (state_q)
      StT0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
      end
      StT1: begin
        // PC is loaded once even if memory stalls the fetch for several cycles.
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = t1_entry_q;
      end
      StT2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      StT3: begin
        case (op_class)
          ClsAlu2:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsAlu1:    begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = ir[31 -: OPW]; end
          ClsMulDiv:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsIllegal: illegal = 1'b1;
          default:    ;
        endcase
      end
      StT4: begin
        case (op_class)
          ClsAlu2:   begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = ir[31 -: OPW]; end
          ClsAlu1:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMulDiv: begin
            Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1; alu_op = ir[31 -: OPW];
          end
          default:   ;
        endcase
      end
      StT5: begin
        case (op_class)
          ClsAlu2:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMulDiv: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:   ;
        endcase
      end
      StT6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
Hardwired control sequencer for the Mini-SRC datapath. It generates every datapath control strobe that the datapath consumes.
- Steps fetch T0–T2, then decodes the IR opcode and executes T3–T6.
- Register selection uses select-and-encode (Gra/Grb/Grc with Rin/Rout).
- Sits directly upstream of Datapath; its outputs drive the datapath control pins one-to-one.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous reset, active low.
- ir  in  32  IR contents from the datapath. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- mem_ready  in  1  memory read data valid.
- stop  in  1  request halt at the next instruction boundary.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout  out  1 each  bus drive enables.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment, memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls.
- alu_op  out  5  ALU operation code presented to the datapath opcode input.
- run  out  1  high while executing.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset behaviour: while clear is low, the state is RESET and every output is 0.
- First rising edge after clear goes high: RESET→T0.
- Output style: Moore outputs, decoded combinationally from the state register plus ir[31:27]. Each strobe is high for the whole cycle of its state.
- run: 1 in T0–T6; 0 in RESET and HALT.
- alu_op: equals ir[31:27] in ALU states, otherwise 0.

Opcode values:
- add 00011, sub 00100, and 00101, or 00110
- shr 00111, shl 01000, ror 01001, rol 01010
- mul 01111, div 10000, neg 10001, not 10010
- nop 11010, halt 11011

Fetch (all instructions):
- T0: PCout, MARin, IncPC, Zlowin.
- T1: Zlowout, PCin, Read, MDRin. Hold in T1, strobes asserted, until mem_ready=1. PCin is asserted only in the first T1 cycle.
- T2: MDRout, IRin.

Execute, binary ALU ops (add..rol):
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, alu_op, Zlowin.
- T5: Zlowout, Gra, Rin. Next state T0.

Execute, unary ops (neg, not):
- T3: Grb, Rout, alu_op, Zlowin.
- T4: Zlowout, Gra, Rin. Next state T0.

Execute, mul/div:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, alu_op, Zlowin, Zhighin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin. Next state T0.

Execute, other opcodes:
- nop: T3, no strobes, next state T0.
- halt: T3→HALT.
- Undefined opcode: handled as nop; illegal=1 during T3.

Halt and stop:
- HALT is exited only by reset.
- stop is sampled at the last execute state (instruction boundary). If it is high there, the next state is HALT instead of T0.
- stop asserted mid-instruction never truncates the instruction.
- stop and a halt opcode together: HALT (same result either way).

Other rules:
- clear asserted in any state forces RESET immediately (asynchronous).
- At most one of the bus-drive outputs is high in any cycle. The bench checks this as an assertion.

Decomposition:
- mini_src_pkg holds:
  - opcode localparams;
  - state encoding: RESET, T0–T6, HALT, 4-bit;
  - op-class encoding: ALU2, ALU1, MULDIV, NOP, HALT, ILLEGAL.
- One sub-module, mini_src_op_decode: combinational opcode → op class.

Test Plan:
1. Reset: hold clear=0 for 3 cycles, release → all outputs 0 in RESET; first edge goes to T0 with PCout=MARin=IncPC=Zlowin=1 and run=1.
2. not R6,R7: ir=0x93380000, mem_ready=1 → T3 has Grb, Rout, Zlowin with alu_op=10010; T4 has Zlowout, Gra, Rin; back to T0. Total 5 cycles.
3. add R3,R1,R2: ir=0x19890000, mem_ready low for 2 T1 cycles → T1 lasts 3 cycles; PCin is high only in the first; T3–T5 sequence as specified; 8 cycles total.
4. mul R3,R4: ir=0x79A00000 → T5 has LOin with Zlowout; T6 has HIin with Zhighout; alu_op=01111 in T4.
5. halt: ir=0xD8000000 → HALT after T3, run=0, stays there for 10 cycles. Separately, stop=1 during T4 of an add → the add completes T5, then HALT.
6. Undefined opcode 11111 → illegal=1 for exactly one cycle in T3, no register strobes, then T0. Separately, clear pulsed low during T4 → immediate RESET with all outputs 0.
